// File: rtl/hazard_monitor.sv
// Observation stage for a two-input gate: counts output transitions in a fixed window after
// each stimulus change and publishes glitch, settle-time and truth-table results.
module hazard_monitor #(
   parameter int unsigned WINDOW = 8,
   parameter int unsigned CNT_W  = 4,
   parameter logic [3:0]  TRUTH  = 4'b0110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             in1,
   input  logic             in2,
   input  logic             dut_out,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] glitch_count,
   output logic [CNT_W-1:0] settle_cycles,
   output logic             hazard,
   output logic             mismatch,
   output logic             overrun
);

   typedef enum logic [1:0] {StIdle, StObserve, StReport} state_e;

   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW);

   state_e state_q, state_d;

   logic [1:0]       cur_vec;
   logic [1:0]       vec_q;
   logic [1:0]       obs_vec_q;
   logic             out_q;
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] trans_q;
   logic [CNT_W-1:0] settle_q;

   logic             result_valid_q;
   logic [CNT_W-1:0] glitch_count_q;
   logic [CNT_W-1:0] settle_cycles_q;
   logic             hazard_q;
   logic             mismatch_q;
   logic             overrun_q;

   logic change;
   logic toggled;
   logic window_done;
   logic start;
   logic restart;
   logic in_observe;
   logic in_report;

   assign cur_vec     = {in1, in2};
   assign change      = (cur_vec != vec_q);
   assign toggled     = (dut_out != out_q);
   assign window_done = (cyc_q == WinLast);
   assign in_observe  = (state_q == StObserve);
   assign in_report   = (state_q == StReport);

   // A new window opens from IDLE or straight out of REPORT; a mid-window change restarts it.
   assign start   = ((state_q == StIdle) || in_report) && change && enable;
   assign restart = in_observe && change;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (change && enable) begin
               state_d = StObserve;
            end
         end
         StObserve: begin
            if (change) begin
               state_d = StObserve;
            end else if (window_done) begin
               state_d = StReport;
            end
         end
         StReport: begin
            if (change && enable) begin
               state_d = StObserve;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy          = in_observe;
      result_valid  = result_valid_q;
      glitch_count  = glitch_count_q;
      settle_cycles = settle_cycles_q;
      hazard        = hazard_q;
      mismatch      = mismatch_q;
      overrun       = overrun_q;
   end

   // Input history and window counters
   always_ff @(posedge clk) begin
      if (reset) begin
         vec_q     <= 2'b00;
         out_q     <= 1'b0;
         obs_vec_q <= 2'b00;
         cyc_q     <= '0;
         trans_q   <= '0;
         settle_q  <= '0;
      end else begin
         vec_q <= cur_vec;
         out_q <= dut_out;
         if (start || restart) begin
            cyc_q     <= CntOne;
            trans_q   <= '0;
            settle_q  <= '0;
            obs_vec_q <= cur_vec;
         end else if (in_observe) begin
            if (toggled) begin
               if (trans_q != CntMax) begin
                  trans_q <= trans_q + CntOne;
               end
               settle_q <= cyc_q;
            end
            cyc_q <= cyc_q + CntOne;
         end
      end
   end

   // Published report, held until the next REPORT
   always_ff @(posedge clk) begin
      if (reset) begin
         result_valid_q  <= 1'b0;
         glitch_count_q  <= '0;
         settle_cycles_q <= '0;
         hazard_q        <= 1'b0;
         mismatch_q      <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         result_valid_q <= in_report;
         if (in_report) begin
            glitch_count_q  <= trans_q;
            settle_cycles_q <= settle_q;
            hazard_q        <= (trans_q > CntOne);
            mismatch_q      <= (out_q != TRUTH[obs_vec_q]);
         end
         if (restart) begin
            overrun_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_monitor.sv
// Directed bench for hazard_monitor: hand-computed reports for clean, glitchy, stuck,
// overrun and mid-window-reset scenarios.
module tb_hazard_monitor;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             in1;
   logic             in2;
   logic             dut_out;
   logic             busy;
   logic             result_valid;
   logic [CNT_W-1:0] glitch_count;
   logic [CNT_W-1:0] settle_cycles;
   logic             hazard;
   logic             mismatch;
   logic             overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int early;

   hazard_monitor #(
      .WINDOW (8),
      .CNT_W  (CNT_W),
      .TRUTH  (4'b0110)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .in1           (in1),
      .in2           (in2),
      .dut_out       (dut_out),
      .busy          (busy),
      .result_valid  (result_valid),
      .glitch_count  (glitch_count),
      .settle_cycles (settle_cycles),
      .hazard        (hazard),
      .mismatch      (mismatch),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges 1..9 of a window; sched[j] is dut_out ahead of edge j. Counts early reports.
   task automatic run_window(input logic [9:0] sched, inout int cnt);
      for (int j = 1; j <= 9; j++) begin
         dut_out = sched[j];
         step();
         if (j < 9 && result_valid) cnt++;
      end
   endtask

   task automatic check_report(input string tag, input int gc, input int sc, input int hz,
                               input int mm);
      check({tag, ".valid"},  32'(result_valid), 1);
      check({tag, ".glitch"}, 32'(glitch_count), 32'(gc));
      check({tag, ".settle"}, 32'(settle_cycles), 32'(sc));
      check({tag, ".hazard"}, 32'(hazard), 32'(hz));
      check({tag, ".mism"},   32'(mismatch), 32'(mm));
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      in1     = 1'b0;
      in2     = 1'b0;
      dut_out = 1'b0;
      step();
      step();
      reset  = 1'b0;
      enable = 1'b1;

      // Idle on 00: no change after reset
      early = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (result_valid || busy) early++;
      end
      check("idle.activity", 32'(early), 0);
      check("idle.glitch", 32'(glitch_count), 0);
      check("idle.settle", 32'(settle_cycles), 0);
      check("idle.hazard", 32'(hazard), 0);
      check("idle.mism", 32'(mismatch), 0);
      check("idle.overrun", 32'(overrun), 0);

      // 00 -> 01, clean rise at cycle 3
      in2 = 1'b1;
      step();
      check("t1.busy", 32'(busy), 1);
      early = 0;
      run_window(10'b1111111000, early);
      check("t1.early", 32'(early), 0);
      check_report("t1", 1, 3, 0, 0);
      step();
      check("t1.pulse", 32'(result_valid), 0);
      check("t1.busy_after", 32'(busy), 0);
      check("t1.hold", 32'(glitch_count), 1);

      // 01 -> 11, dynamic hazard: edges at cycles 2, 3, 4, ends low
      in1 = 1'b1;
      step();
      early = 0;
      run_window(10'b0000001010, early);
      check("t2.early", 32'(early), 0);
      check_report("t2", 3, 4, 1, 0);
      step();

      // 11 -> 10, output stuck low
      in2 = 1'b0;
      step();
      early = 0;
      run_window(10'b0000000000, early);
      check("t3.early", 32'(early), 0);
      check_report("t3", 0, 0, 0, 1);
      check("t3.overrun", 32'(overrun), 0);
      step();

      // Back to 00 with enable low: change dropped
      enable = 1'b0;
      in1    = 1'b0;
      step();
      step();
      check("drop.busy", 32'(busy), 0);

      // 00 -> 01, then 01 -> 10 at cycle 4 of the window
      enable  = 1'b1;
      in2     = 1'b1;
      dut_out = 1'b1;
      step();
      early = 0;
      for (int j = 1; j <= 3; j++) begin
         step();
         if (result_valid) early++;
      end
      in1 = 1'b1;
      in2 = 1'b0;
      step();
      check("ovr.flag", 32'(overrun), 1);
      check("ovr.busy", 32'(busy), 1);
      run_window(10'b1111111111, early);
      check("ovr.early", 32'(early), 0);
      check_report("ovr", 0, 0, 0, 0);
      check("ovr.sticky", 32'(overrun), 1);
      step();

      // Reset at cycle 5 of a window
      in2 = 1'b1;
      step();
      for (int j = 1; j <= 5; j++) step();
      check("rst.busy_pre", 32'(busy), 1);
      reset = 1'b1;
      step();
      check("rst.busy", 32'(busy), 0);
      check("rst.valid", 32'(result_valid), 0);
      check("rst.overrun", 32'(overrun), 0);
      check("rst.glitch", 32'(glitch_count), 0);
      check("rst.mism", 32'(mismatch), 0);
      reset   = 1'b0;
      enable  = 1'b0;
      in1     = 1'b0;
      in2     = 1'b0;
      dut_out = 1'b0;
      early   = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (result_valid || busy) early++;
      end
      check("rst.quiet", 32'(early), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
